branch_hazard_ctrl: RTL
=======================

Name: branch_hazard_ctrl

Overview:
- Pipeline hazard controller for the ID-stage branch comparator and the ID-stage operand path.
- Tracks in-flight register writers in the E, M and W stages, using per-record Tnew (cycles until the result exists).
- Decides each cycle whether the D-stage instruction stalls, and selects the forwarding source for the comparator's rs/rt operands.
- Sits beside the decoder; drives the F/D enable, inserts the E-stage bubble and drives the comparator operand muxes.

Parameters:
MD_MULT_CYC, 5, busy cycles for mult/multu (optional feature only)
MD_DIV_CYC, 10, busy cycles for div/divu (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
d_rs_addr  in  5  rs field of the D-stage instruction
d_rt_addr  in  5  rt field of the D-stage instruction
d_tuse_rs  in  2  cycles until D needs rs; 3 = rs not used
d_tuse_rt  in  2  cycles until D needs rt; 3 = rt not used
d_wr_addr  in  5  destination register of D; 0 = no write
d_tnew  in  2  Tnew of D's result when it enters E (0..2)
d_md_op  in  2  0 none, 1 mult-type, 2 div-type, 3 mf/mt hi-lo (optional feature)
stall  out  1  freeze PC and F/D; bubble into E
fwd_sel_rs  out  2  0 regfile, 1 E, 2 M, 3 W
fwd_sel_rt  out  2  as fwd_sel_rs
md_busy  out  1  multiply/divide counter nonzero (optional feature; else tied 0)

Behaviour:
- State: three records, E, M and W, each holding {addr[4:0], tnew[1:0]}.
- Reset value: all records {0,0}, i.e. bubbles. With all records empty, stall=0, fwd_sel_rs=0, fwd_sel_rt=0, md_busy=0.
- Async reset mid-operation clears all records and the busy counter immediately; outputs fall to their reset values within the same cycle.
- Per rising edge, when stall=0:
  - E <= {d_wr_addr, d_tnew}
  - M <= {E.addr, sat_dec(E.tnew)}
  - W <= {M.addr, 0}
  - sat_dec(x) = x==0 ? 0 : x-1
- Per rising edge, when stall=1:
  - E <= {0,0} (bubble)
  - M and W advance exactly as when stall=0.
- Stall is combinational from the registered records plus the D inputs. For operand r in {rs, rt}, hazard_r is true when:
  - r_addr != 0, and
  - tuse_r != 3, and
  - (E.addr==r_addr and tuse_r < E.tnew) or (M.addr==r_addr and tuse_r < M.tnew).
- stall = hazard_rs | hazard_rt (| md_stall when the optional feature is compiled in).
- Forwarding select per operand, priority E > M > W:
  - 1 if E.addr==r_addr, r_addr!=0 and E.tnew==0
  - else 2 if M.addr==r_addr, r_addr!=0 and M.tnew==0
  - else 3 if W.addr==r_addr and r_addr!=0
  - else 0
- A younger matching writer with tnew>0 must not be bypassed by an older ready one. If E matches with E.tnew>0, the select falls to 0 and stall covers the case.
- Register 0 never causes a stall or a forward, whatever addr/tnew say.
- Zero-latency path: the outputs are valid in the same cycle the D inputs change. No handshake.

Optional Feature:
- Macro: BRANCH_HAZARD_MD_STALL_EN.
- When defined:
  - A 4-bit busy counter is present.
  - When stall=0 and d_md_op==1, the counter loads MD_MULT_CYC on the edge.
  - When stall=0 and d_md_op==2, the counter loads MD_DIV_CYC on the edge.
  - Otherwise the counter decrements, saturating at 0.
  - md_busy = (count != 0).
  - md_stall = (d_md_op != 0) & md_busy.
  - A new md op issued while busy is impossible, because it stalls.
  - Counter reset value is 0.
- When undefined: no counter, md_busy tied 0, md_stall=0, d_md_op ignored.

Decomposition:
- Shared settings header holds:
  - FWD_RF/FWD_E/FWD_M/FWD_W encodings
  - TUSE_NONE=3
  - MD_OP_* encodings
  - opcode-to-Tuse/Tnew constants consumed by the decoder
- One natural sub-module: hazard_operand_chk, instantiated twice (rs, rt). It takes r_addr, tuse_r and the E/M/W records, and outputs hazard_r and fwd_sel_r.

Test Plan:
- Load-use into beq: cycle0 D: lw $8 (wr=8, tnew=2). Cycle1 D: beq $8,$9 (tuse_rs=0). Required: stall=1 in cycles 1 and 2, stall=0 in cycle 3 with fwd_sel_rs=3 (W) and fwd_sel_rt=0.
- ALU-to-branch: addu $5 (tnew=1) then bne $5,$0 (tuse=0). Required: stall=1 for one cycle, then fwd_sel_rs=2 (M).
- Zero-latency producer: lui $3 (tnew=0) then beq $3,$3. Required: stall=0, fwd_sel_rs=fwd_sel_rt=1 (E).
- $0 immunity: lw $0 followed by beq $0,$0. Required: stall=0 and both selects 0.
- Reset mid-stall: assert reset while stall=1. Required: same cycle stall=0 and selects 0; after release, the records behave as empty.
- With BRANCH_HAZARD_MD_STALL_EN: issue mult (d_md_op=1), then present mfhi (d_md_op=3) next. Required: md_busy=1 and stall=1 for exactly 5 cycles, then stall=0.

Source files
------------

// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared encodings, Tuse/Tnew constants and the E/M/W writer record for branch_hazard_ctrl.
package branch_hazard_ctrl_pkg;

    typedef struct packed {
        logic [4:0] addr;
        logic [1:0] tnew;
    } wr_rec_t;

    localparam int NUM_OPS = 2;  // rs, rt

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] MD_OP_NONE  = 2'd0;
    localparam logic [1:0] MD_OP_MULT  = 2'd1;
    localparam logic [1:0] MD_OP_DIV   = 2'd2;
    localparam logic [1:0] MD_OP_HILO  = 2'd3;

    // Decoder-facing opcode class constants
    localparam logic [1:0] TUSE_BRANCH = 2'd0;
    localparam logic [1:0] TUSE_ALU    = 2'd1;
    localparam logic [1:0] TUSE_STORE  = 2'd2;
    localparam logic [1:0] TNEW_LUI    = 2'd0;
    localparam logic [1:0] TNEW_ALU    = 2'd1;
    localparam logic [1:0] TNEW_LOAD   = 2'd2;

    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

endpackage

// File: rtl/branch_hazard_ctrl_operand_chk.sv
// Per-operand hazard detect and forward-source select against the E/M/W writer records.
module hazard_operand_chk
    import branch_hazard_ctrl_pkg::*;
(
    input  logic [4:0] r_addr,
    input  logic [1:0] tuse_r,
    input  wr_rec_t    e_rec,
    input  wr_rec_t    m_rec,
    input  wr_rec_t    w_rec,
    output logic       hazard_r,
    output logic [1:0] fwd_sel_r
);
    logic e_hit, m_hit, w_hit;

    always_comb begin
        e_hit = (r_addr != 5'd0) && (e_rec.addr == r_addr);
        m_hit = (r_addr != 5'd0) && (m_rec.addr == r_addr);
        w_hit = (r_addr != 5'd0) && (w_rec.addr == r_addr);

        hazard_r = (tuse_r != TUSE_NONE) &&
                   ((e_hit && (tuse_r < e_rec.tnew)) || (m_hit && (tuse_r < m_rec.tnew)));

        // Youngest matching writer decides; a not-yet-ready one blocks older bypasses.
        fwd_sel_r = FWD_RF;
        if (e_hit)
            fwd_sel_r = (e_rec.tnew == 2'd0) ? FWD_E : FWD_RF;
        else if (m_hit)
            fwd_sel_r = (m_rec.tnew == 2'd0) ? FWD_M : FWD_RF;
        else if (w_hit)
            fwd_sel_r = FWD_W;
    end
endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage hazard controller: stall and comparator forwarding selects from E/M/W records.
// Optional mult/div busy stall compiled in with BRANCH_HAZARD_MD_STALL_EN.
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int MD_MULT_CYC = 5,
    parameter int MD_DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs_addr,
    input  logic [4:0] d_rt_addr,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_wr_addr,
    input  logic [1:0] d_tnew,
    input  logic [1:0] d_md_op,
    output logic       stall,
    output logic [1:0] fwd_sel_rs,
    output logic [1:0] fwd_sel_rt,
    output logic       md_busy
);
    wr_rec_t e_rec, m_rec, w_rec;

    logic [NUM_OPS-1:0][4:0] op_addr;
    logic [NUM_OPS-1:0][1:0] op_tuse;
    logic [NUM_OPS-1:0]      op_haz;
    logic [NUM_OPS-1:0][1:0] op_sel;
    logic                    md_stall;

    assign op_addr = {d_rt_addr, d_rs_addr};
    assign op_tuse = {d_tuse_rt, d_tuse_rs};

    genvar g;
    generate
        for (g = 0; g < NUM_OPS; g++) begin : g_op
            hazard_operand_chk u_chk (
                .r_addr    (op_addr[g]),
                .tuse_r    (op_tuse[g]),
                .e_rec     (e_rec),
                .m_rec     (m_rec),
                .w_rec     (w_rec),
                .hazard_r  (op_haz[g]),
                .fwd_sel_r (op_sel[g])
            );
        end
    endgenerate

    assign fwd_sel_rs = op_sel[0];
    assign fwd_sel_rt = op_sel[1];
    assign stall      = (|op_haz) | md_stall;

    // A stall freezes D, so E takes a bubble while M/W keep draining.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_rec <= '0;
            m_rec <= '0;
            w_rec <= '0;
        end else begin
            e_rec <= stall ? '0 : wr_rec_t'{addr: d_wr_addr, tnew: d_tnew};
            m_rec <= wr_rec_t'{addr: e_rec.addr, tnew: sat_dec(e_rec.tnew)};
            w_rec <= wr_rec_t'{addr: m_rec.addr, tnew: 2'd0};
        end
    end

`ifdef BRANCH_HAZARD_MD_STALL_EN
    logic [3:0] md_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            md_cnt <= 4'd0;
        else if (!stall && d_md_op == MD_OP_MULT)
            md_cnt <= 4'(MD_MULT_CYC);
        else if (!stall && d_md_op == MD_OP_DIV)
            md_cnt <= 4'(MD_DIV_CYC);
        else if (md_cnt != 4'd0)
            md_cnt <= md_cnt - 4'd1;
    end

    assign md_busy  = (md_cnt != 4'd0);
    assign md_stall = (d_md_op != MD_OP_NONE) && md_busy;
`else
    logic [3:0] unused_md;
    assign unused_md = 4'(MD_MULT_CYC) ^ 4'(MD_DIV_CYC) ^ {2'b00, d_md_op};
    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
`endif

endmodule
